// File: rtl/doorlock_pkg.sv
// Shared doorlock definitions: key codes, scanner FSM encoding and row-pattern helpers.
package doorlock_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } scan_state_e;

  // Active-low one-hot drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Active-low pattern with only the given row pulled low.
  function automatic logic [3:0] row_mask(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic single_low(input logic [3:0] rows);
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    case (rows)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Combinational (row, column) to key-code lookup for the 4x4 doorlock keypad.
module keypad_keymap
  import doorlock_pkg::*;
(
  input  logic [1:0] row_i,
  input  logic [1:0] col_i,
  output logic [3:0] code_c_o
);

  always_comb begin
    code_c_o = 4'h0;
    case ({row_i, col_i})
      4'b00_00: code_c_o = 4'h1;
      4'b00_01: code_c_o = 4'h2;
      4'b00_10: code_c_o = 4'h3;
      4'b00_11: code_c_o = 4'hA;
      4'b01_00: code_c_o = 4'h4;
      4'b01_01: code_c_o = 4'h5;
      4'b01_10: code_c_o = 4'h6;
      4'b01_11: code_c_o = 4'hB;
      4'b10_00: code_c_o = 4'h7;
      4'b10_01: code_c_o = 4'h8;
      4'b10_10: code_c_o = 4'h9;
      4'b10_11: code_c_o = 4'hC;
      4'b11_00: code_c_o = KEY_STAR;
      4'b11_01: code_c_o = 4'h0;
      4'b11_10: code_c_o = KEY_HASH;
      4'b11_11: code_c_o = 4'hD;
      default:  code_c_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with press/release debounce; one key event per keystroke.
// Define KEYPAD_ROW_SYNC_EN to pass row_in through a 2-flop synchronizer.
module keypad_scanner
  import doorlock_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] ps_num,
  output logic       key_valid,
  output logic       ps_start,
  output logic       ps_end
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT);

  scan_state_e      state_q;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [1:0]       row_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       rows_c;
  logic [3:0]       code_c;
  logic             slot_end_c;

`ifdef KEYPAD_ROW_SYNC_EN
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Idle (all-high) reset value so no phantom press follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
    end
  end

  assign rows_c = sync2_q;
`else
  assign rows_c = row_in;
`endif

  assign idx_d      = idx_q + 2'd1;
  assign slot_end_c = (div_q == DIV_W'(SCAN_DIV - 1));

  keypad_keymap u_keymap (
    .row_i    (row_q),
    .col_i    (idx_q),
    .code_c_o (code_c)
  );

  // Scan / debounce / hold FSM; the column index only moves when leaving a slot or a key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      idx_q     <= 2'd0;
      row_q     <= 2'd0;
      div_q     <= '0;
      cnt_q     <= '0;
      col_out   <= 4'b1110;
      ps_num    <= 4'h0;
      key_valid <= 1'b0;
      ps_start  <= 1'b0;
      ps_end    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      ps_start  <= 1'b0;
      ps_end    <= 1'b0;
      unique case (state_q)
        SCAN: begin
          if (slot_end_c) begin
            div_q <= '0;
            if (single_low(rows_c)) begin
              row_q   <= low_row_idx(rows_c);
              cnt_q   <= '0;
              state_q <= DEBOUNCE;
            end else begin
              idx_q   <= idx_d;
              col_out <= col_drive(idx_d);
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        DEBOUNCE: begin
          if (rows_c == row_mask(row_q)) begin
            if (cnt_q >= CNT_W'(DEBOUNCE_CNT - 2)) begin
              ps_num    <= code_c;
              key_valid <= 1'b1;
              ps_start  <= (code_c == KEY_STAR);
              ps_end    <= (code_c == KEY_HASH);
              cnt_q     <= '0;
              state_q   <= HELD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q   <= '0;
            idx_q   <= idx_d;
            col_out <= col_drive(idx_d);
            state_q <= SCAN;
          end
        end
        HELD: begin
          if (rows_c == 4'hF) begin
            if (cnt_q >= CNT_W'(DEBOUNCE_CNT - 1)) begin
              cnt_q   <= '0;
              idx_q   <= idx_d;
              col_out <= col_drive(idx_d);
              state_q <= SCAN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        default: begin
          cnt_q   <= '0;
          div_q   <= '0;
          state_q <= SCAN;
        end
      endcase
    end
  end

endmodule
